cmp_hazard_ctrl: RTL and testbench

CMP_HAZARD_CTRL -- requirements
Module: cmp_hazard_ctrl

---
 rtl/cmp_hazard_ctrl_pkg.sv | 38 +++
 rtl/cmp_hazard_ctrl_if.sv | 33 +++
 rtl/cmp_hazard_ctrl_src_check.sv | 47 ++++
 rtl/cmp_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_cmp_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_hazard_ctrl_pkg.sv
// Shared CPU definitions for the branch-comparator hazard controller.
// Holds the opcode/funct/rt-field constants used to decode comparator
// instructions, the forward-select encodings and the writer slot record.
package cmp_hazard_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FUNCT_MOVZ = 6'b001010;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    // One in-flight register writer: tnew counts cycles until its result
    // can be forwarded from the stage the slot represents.
    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic [1:0] tnew;
    } slot_t;

    // Age a writer by one stage; results never become "less than ready".
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/cmp_hazard_ctrl_if.sv
// Bus bundle between the D stage / pipeline control and the hazard controller.
//   instr_d    : D-stage instruction feeding the branch comparator
//   wr_en_d    : D instruction writes the register file
//   wr_addr_d  : D instruction destination register
//   tnew_d     : cycles from E entry until the result can be forwarded
//   ext_stall  : pipeline frozen by another unit
//   stall      : hold PC/D, bubble into E
//   fwd_rs_sel : comparator RD1 source (RF/E/M/W)
//   fwd_rt_sel : comparator RD2 source (RF/E/M/W)
//   stall_cnt  : saturating count of hazard stall cycles
interface cmp_hazard_ctrl_if;

    logic [31:0] instr_d;
    logic        wr_en_d;
    logic [4:0]  wr_addr_d;
    logic [1:0]  tnew_d;
    logic        ext_stall;
    logic        stall;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic [15:0] stall_cnt;

    modport master (
        output instr_d, wr_en_d, wr_addr_d, tnew_d, ext_stall,
        input  stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

    modport slave (
        input  instr_d, wr_en_d, wr_addr_d, tnew_d, ext_stall,
        output stall, fwd_rs_sel, fwd_rt_sel, stall_cnt
    );

endinterface

// File: rtl/cmp_hazard_ctrl_src_check.sv
// Per-source hazard check for one comparator operand.
//   src_i    : source register number
//   used_i   : the D instruction actually reads this source
//   slot_*_i : E, M and W writer slots
//   stall_o  : youngest matching E/M writer is not ready yet
//   sel_o    : forwarding source for this operand
module cmp_src_check
    import cmp_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       used_i,
    input  slot_t      slot_e_i,
    input  slot_t      slot_m_i,
    input  slot_t      slot_w_i,
    output logic       stall_o,
    output fwd_sel_e   sel_o
);

    logic hit_e;
    logic hit_m;
    logic hit_w;

    // $0 is hard-wired, so a write to it never creates a dependency.
    assign hit_e = used_i && (src_i != 5'd0) && slot_e_i.valid && (slot_e_i.addr == src_i);
    assign hit_m = used_i && (src_i != 5'd0) && slot_m_i.valid && (slot_m_i.addr == src_i);
    assign hit_w = used_i && (src_i != 5'd0) && slot_w_i.valid && (slot_w_i.addr == src_i);

    always_comb begin
        stall_o = 1'b0;
        sel_o   = FWD_RF;
        // The youngest match owns the value; an older slot behind it is stale.
        if (hit_e) begin
            stall_o = (slot_e_i.tnew != 2'd0);
        end else if (hit_m) begin
            stall_o = (slot_m_i.tnew != 2'd0);
        end

        if (hit_e && (slot_e_i.tnew == 2'd0)) begin
            sel_o = FWD_E;
        end else if (hit_m && (slot_m_i.tnew == 2'd0)) begin
            sel_o = FWD_M;
        end else if (hit_w) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/cmp_hazard_ctrl.sv
// Hazard controller for the D-stage branch comparator.
// Tracks the E/M/W register writers, stalls D when a comparator operand
// depends on a result that is not yet forwardable, otherwise selects the
// forwarding source, and counts hazard stall cycles (saturating).
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : cmp_hazard_ctrl_if slave (D-stage inputs, stall/forward outputs)
module cmp_hazard_ctrl
    import cmp_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    cmp_hazard_ctrl_if.slave  bus
);

    slot_t       e_q, e_d;
    slot_t       m_q, m_d;
    slot_t       w_q, w_d;
    logic [15:0] cnt_q, cnt_d;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic        use_rs;
    logic        use_rt;
    logic        rs_stall;
    logic        rt_stall;
    fwd_sel_e    rs_sel;
    fwd_sel_e    rt_sel;
    logic        stall;
    logic        unused_instr_bits;

    assign op    = bus.instr_d[31:26];
    assign rs    = bus.instr_d[25:21];
    assign rt    = bus.instr_d[20:16];
    assign funct = bus.instr_d[5:0];
    assign unused_instr_bits = ^bus.instr_d[15:6];

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (op)
            OP_BEQ, OP_BNE: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: begin
                use_rs = 1'b1;
            end
            OP_REGIMM: begin
                // Here rt selects the branch kind, it is not an operand.
                use_rs = (rt == RT_BLTZ) || (rt == RT_BGEZ);
            end
            OP_SPECIAL: begin
                use_rs = (funct == FUNCT_MOVZ);
                use_rt = (funct == FUNCT_MOVZ);
            end
            default: begin
                use_rs = 1'b0;
                use_rt = 1'b0;
            end
        endcase
    end

    cmp_src_check u_rs_check (
        .src_i    (rs),
        .used_i   (use_rs),
        .slot_e_i (e_q),
        .slot_m_i (m_q),
        .slot_w_i (w_q),
        .stall_o  (rs_stall),
        .sel_o    (rs_sel)
    );

    cmp_src_check u_rt_check (
        .src_i    (rt),
        .used_i   (use_rt),
        .slot_e_i (e_q),
        .slot_m_i (m_q),
        .slot_w_i (w_q),
        .stall_o  (rt_stall),
        .sel_o    (rt_sel)
    );

    assign stall          = rs_stall | rt_stall;
    assign bus.stall      = stall;
    assign bus.fwd_rs_sel = stall ? FWD_RF : rs_sel;
    assign bus.fwd_rt_sel = stall ? FWD_RF : rt_sel;
    assign bus.stall_cnt  = cnt_q;

    always_comb begin
        e_d   = e_q;
        m_d   = m_q;
        w_d   = w_q;
        cnt_d = cnt_q;
        // An external freeze holds everything, including the counter.
        if (!bus.ext_stall) begin
            m_d.valid = e_q.valid;
            m_d.addr  = e_q.addr;
            m_d.tnew  = tnew_dec(e_q.tnew);
            w_d.valid = m_q.valid;
            w_d.addr  = m_q.addr;
            w_d.tnew  = 2'd0;
            if (stall) begin
                e_d = '0;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end else begin
                e_d.valid = bus.wr_en_d;
                e_d.addr  = bus.wr_addr_d;
                e_d.tnew  = bus.tnew_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cmp_hazard_ctrl.sv
module tb_cmp_hazard_ctrl;

    logic clk;
    logic reset;

    cmp_hazard_ctrl_if bus ();

    cmp_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: each slot remembers the writer's original tnew; its
    // age in stages (0=E,1=M,2=W) tells how much waiting remains.
    bit mv[3];
    int ma[3];
    int mt[3];
    int mcnt;
    bit m_stall;
    int m_rs;
    int m_rt;

    typedef struct {
        logic [31:0] instr;
        logic        we;
        logic [4:0]  addr;
        logic [1:0]  tnew;
        logic        ext;
        logic        rst;
        logic        chk;
        logic        stall;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    function automatic logic [31:0] enc_movz(input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, 5'd1, 5'd0, 6'b001010};
    endfunction

    localparam logic [31:0] I_ADDU = {6'b000000, 5'd1, 5'd2, 5'd5, 5'd0, 6'b100001};
    localparam logic [31:0] I_LW   = {6'b100011, 5'd0, 5'd3, 16'h0000};
    localparam logic [31:0] I_JAL  = {6'b000011, 26'h0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void src_eval(input int s, input bit used, output bit st, output int sel);
        st  = 1'b0;
        sel = 0;
        if (!used || s == 0) return;
        for (int i = 0; i < 2; i++) begin
            if (mv[i] && ma[i] == s) begin
                st = (mt[i] - i) > 0;
                break;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (mv[i] && ma[i] == s && (i == 2 || (mt[i] - i) <= 0)) begin
                sel = i + 1;
                break;
            end
        end
    endfunction

    function automatic void model_eval();
        logic [5:0] op;
        int rs, rt;
        bit urs, urt, srs, srt;
        int ss, st;
        op  = bus.instr_d[31:26];
        rs  = int'(bus.instr_d[25:21]);
        rt  = int'(bus.instr_d[20:16]);
        urs = (op == 6'b000100) || (op == 6'b000101) || (op == 6'b000110) || (op == 6'b000111) ||
              (op == 6'b000001 && rt < 2) ||
              (op == 6'b000000 && bus.instr_d[5:0] == 6'b001010);
        urt = (op == 6'b000100) || (op == 6'b000101) ||
              (op == 6'b000000 && bus.instr_d[5:0] == 6'b001010);
        src_eval(rs, urs, srs, ss);
        src_eval(rt, urt, srt, st);
        m_stall = srs || srt;
        m_rs    = m_stall ? 0 : ss;
        m_rt    = m_stall ? 0 : st;
    endfunction

    function automatic void model_update();
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                mv[i] = 1'b0; ma[i] = 0; mt[i] = 0;
            end
            mcnt = 0;
        end else if (!bus.ext_stall) begin
            mv[2] = mv[1]; ma[2] = ma[1]; mt[2] = mt[1];
            mv[1] = mv[0]; ma[1] = ma[0]; mt[1] = mt[0];
            if (m_stall) begin
                mv[0] = 1'b0; ma[0] = 0; mt[0] = 0;
                if (mcnt < 65535) mcnt++;
            end else begin
                mv[0] = bus.wr_en_d; ma[0] = int'(bus.wr_addr_d); mt[0] = int'(bus.tnew_d);
            end
        end
    endfunction

    task automatic drive(input logic [31:0] instr, input logic we, input logic [4:0] a,
                         input logic [1:0] t, input logic ext, input logic rst);
        bus.instr_d   = instr;
        bus.wr_en_d   = we;
        bus.wr_addr_d = a;
        bus.tnew_d    = t;
        bus.ext_stall = ext;
        reset         = rst;
        #1;
        model_eval();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic add(input logic [31:0] instr, input logic we, input logic [4:0] a, input logic [1:0] t,
                       input logic ext, input logic rst, input logic c, input logic s,
                       input logic [1:0] rs, input logic [1:0] rt, input logic [15:0] cnt);
        vec_t v;
        v = '{instr, we, a, t, ext, rst, c, s, rs, rt, cnt};
        vt.push_back(v);
    endtask

    initial begin
        int nst;
        int iters;
        mcnt = 0;
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0; ma[i] = 0; mt[i] = 0;
        end

        // reset, then beq $1,$2
        add(enc_i(6'b000100, 5'd1, 5'd2), 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);
        add(enc_i(6'b000100, 5'd1, 5'd2), 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd0);
        add(enc_i(6'b000100, 5'd1, 5'd2), 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'd0);
        // load-use: lw $3 then beq $3,$0
        add(I_LW,                         1, 3, 2, 0, 1, 1, 0, 0, 0, 16'd0);
        add(enc_i(6'b000100, 5'd3, 5'd0), 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'd0);
        add(enc_i(6'b000100, 5'd3, 5'd0), 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'd1);
        add(enc_i(6'b000100, 5'd3, 5'd0), 0, 0, 0, 0, 1, 1, 0, 3, 0, 16'd2);
        // ALU dependency: addu $5 then bne $5,$6
        add(I_ADDU,                       1, 5, 1, 0, 1, 1, 0, 0, 0, 16'd2);
        add(enc_i(6'b000101, 5'd5, 5'd6), 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'd2);
        add(enc_i(6'b000101, 5'd5, 5'd6), 0, 0, 0, 0, 1, 1, 0, 2, 0, 16'd3);
        // youngest match: jal $31, addu $31, bgez $31
        add(I_JAL,                        1, 31, 0, 0, 1, 1, 0, 0, 0, 16'd3);
        add(I_ADDU,                       1, 31, 1, 0, 1, 1, 0, 0, 0, 16'd3);
        add(enc_i(6'b000001, 5'd31, 5'd1), 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'd3);
        add(enc_i(6'b000001, 5'd31, 5'd1), 0, 0, 0, 0, 1, 1, 0, 2, 0, 16'd4);
        // $0 never hazards
        add(I_LW,                         1, 0, 2, 0, 1, 1, 0, 0, 0, 16'd4);
        add(enc_i(6'b000100, 5'd0, 5'd0), 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'd4);
        // lw $4, blez $4 under a 3-cycle external freeze
        add(I_LW,                         1, 4, 2, 0, 1, 1, 0, 0, 0, 16'd4);
        add(enc_i(6'b000110, 5'd4, 5'd0), 0, 0, 0, 1, 1, 1, 1, 0, 0, 16'd4);
        add(enc_i(6'b000110, 5'd4, 5'd0), 0, 0, 0, 1, 1, 1, 1, 0, 0, 16'd4);
        add(enc_i(6'b000110, 5'd4, 5'd0), 0, 0, 0, 1, 1, 1, 1, 0, 0, 16'd4);
        add(enc_i(6'b000110, 5'd4, 5'd0), 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'd4);
        add(enc_i(6'b000110, 5'd4, 5'd0), 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'd5);
        add(enc_i(6'b000110, 5'd4, 5'd0), 0, 0, 0, 0, 1, 1, 0, 3, 0, 16'd6);
        // reset in the middle of a stall
        add(I_LW,                         1, 7, 2, 0, 1, 1, 0, 0, 0, 16'd6);
        add(enc_i(6'b000100, 5'd7, 5'd7), 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'd6);
        add(enc_i(6'b000100, 5'd7, 5'd7), 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'd7);
        add(enc_i(6'b000100, 5'd7, 5'd7), 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'd0);
        // lui-class writer forwarded straight from E into movz rt
        add(32'h0,                        1, 8, 0, 0, 1, 1, 0, 0, 0, 16'd0);
        add(enc_movz(5'd9, 5'd8),         0, 0, 0, 0, 1, 1, 0, 0, 1, 16'd0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].instr, vt[i].we, vt[i].addr, vt[i].tnew, vt[i].ext, vt[i].rst);
            if (vt[i].chk) begin
                chk($sformatf("vec%0d stall", i), {31'b0, bus.stall}, {31'b0, vt[i].stall});
                chk($sformatf("vec%0d rs_sel", i), {30'b0, bus.fwd_rs_sel}, {30'b0, vt[i].rs});
                chk($sformatf("vec%0d rt_sel", i), {30'b0, bus.fwd_rt_sel}, {30'b0, vt[i].rt});
                chk($sformatf("vec%0d stall_cnt", i), {16'b0, bus.stall_cnt}, {16'b0, vt[i].cnt});
            end
            step();
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            logic [4:0]  ra, rb;
            ra = 5'($urandom_range(0, 3));
            rb = 5'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: ins = enc_i(6'b000100, ra, rb);
                1: ins = enc_i(6'b000101, ra, rb);
                2: ins = enc_i(6'b000110, ra, rb);
                3: ins = enc_i(6'b000111, ra, rb);
                4: ins = enc_i(6'b000001, ra, 5'($urandom_range(0, 2)));
                5: ins = enc_movz(ra, rb);
                6: ins = enc_i(6'b100011, ra, rb);
                default: ins = I_ADDU;
            endcase
            drive(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0), (i >= 2) && ($urandom_range(0, 49) != 0));
            if (i >= 2) begin
                chk($sformatf("rnd%0d stall", i), {31'b0, bus.stall}, {31'b0, m_stall});
                chk($sformatf("rnd%0d rs_sel", i), {30'b0, bus.fwd_rs_sel}, 32'(m_rs));
                chk($sformatf("rnd%0d rt_sel", i), {30'b0, bus.fwd_rt_sel}, 32'(m_rt));
                chk($sformatf("rnd%0d stall_cnt", i), {16'b0, bus.stall_cnt}, 32'(mcnt));
            end
            step();
        end

        // saturation: a lw-style writer to $3 reappears behind every stall pair
        drive(32'h0, 0, 0, 0, 0, 0);
        step();
        nst = 0;
        iters = 0;
        while (nst < 65537 && iters < 99000) begin
            drive(enc_i(6'b000100, 5'd3, 5'd3), 1, 3, 2, 0, 1);
            if (m_stall) nst++;
            step();
            iters++;
            if (m_stall && nst == 65534) begin
                chk("sat_minus_one", {16'b0, bus.stall_cnt}, 32'h0000_FFFE);
            end
        end
        chk("sat_budget", 32'(nst), 32'd65537);
        drive(32'h0, 0, 0, 0, 0, 1);
        chk("sat_value", {16'b0, bus.stall_cnt}, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
